// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: bus types, chip-enable
// levels, loader state encodings and big-endian word packing.
package inst_rom_loader_pkg;

    localparam int InstW      = 32;
    localparam int InstAddrW  = 10;
    localparam int InstMemNum = 2 ** InstAddrW;

    typedef logic [InstW-1:0] InstBus;
    typedef logic [31:0]      InstAddrBus;

    localparam InstBus ZeroWord    = 32'h0000_0000;
    localparam logic   ChipEnable  = 1'b1;
    localparam logic   ChipDisable = 1'b0;

    typedef enum logic {
        LdLoad = 1'b0,
        LdRun  = 1'b1
    } ld_state_e;

    function automatic int mem_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Merge the bytes already collected (hi) with the incoming byte at
    // position cnt; positions not yet filled read as zero.
    function automatic InstBus pack_word(input logic [23:0] hi,
                                         input logic [7:0]  b,
                                         input logic [1:0]  cnt);
        InstBus w;
        case (cnt)
            2'd0:    w = {b, 24'h00_0000};
            2'd1:    w = {hi[23:16], b, 16'h0000};
            2'd2:    w = {hi[23:8], b, 8'h00};
            default: w = {hi, b};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Single write port, asynchronous read instruction RAM. Contents are never
// cleared, so a reset keeps whatever was last written.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int Depth = mem_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [0:Depth-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with a byte-stream loader: holds the core in reset while
// an image is streamed in, then serves fetches until a reload is requested.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [INST_W-1:0] rom_data_o,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              reload_req_i,
    output logic              cpu_rst_o,
    output logic [ADDR_W:0]   words_o,
    output logic              load_err_o
);

    localparam int              Depth    = mem_depth(ADDR_W);
    localparam logic [ADDR_W:0] WordsMax = (ADDR_W + 1)'(Depth);

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;
    logic              r_ready;
    logic              r_cpu_rst;
    logic              r_err;
    logic [ADDR_W:0]   r_words;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;

    logic              w_accept;
    logic              w_word_done;
    logic              w_full;
    logic              w_we;
    InstBus            w_word;
    logic [INST_W-1:0] w_rdata;
    logic              w_unused_addr;

    assign w_unused_addr = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

    // Handshake, word assembly and write qualification.
    always_comb begin
        w_accept    = ld_valid_i && r_ready;
        w_word      = pack_word(r_asm, ld_byte_i, r_byte_cnt);
        w_word_done = w_accept && (ld_last_i || (r_byte_cnt == 2'd3));
        w_full      = (r_words == WordsMax);
        w_we        = w_word_done && !w_full;
    end

    // Loader next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LdLoad: begin
                if (w_accept && ld_last_i) begin
                    w_state_nxt = LdRun;
                end else begin
                    w_state_nxt = LdLoad;
                end
            end
            LdRun: begin
                if (reload_req_i) begin
                    w_state_nxt = LdLoad;
                end else begin
                    w_state_nxt = LdRun;
                end
            end
            default: w_state_nxt = LdLoad;
        endcase
    end

    // State register plus the handshake/core-reset outputs that mirror it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LdLoad;
            r_ready   <= 1'b1;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt == LdLoad);
            r_cpu_rst <= (w_state_nxt == LdLoad);
        end
    end

    // Byte counter, assembly register, word count and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'h00_0000;
            r_words    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                LdLoad: begin
                    if (w_word_done) begin
                        r_byte_cnt <= 2'd0;
                        r_asm      <= 24'h00_0000;
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_words <= r_words + 1'b1;
                        end
                    end else if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= w_word[31:8];
                    end
                end
                LdRun: begin
                    if (reload_req_i) begin
                        r_byte_cnt <= 2'd0;
                        r_asm      <= 24'h00_0000;
                        r_words    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                default: begin
                    r_byte_cnt <= 2'd0;
                    r_asm      <= 24'h00_0000;
                end
            endcase
        end
    end

    inst_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_words[ADDR_W-1:0]),
        .wdata (w_word),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (w_rdata)
    );

    // Fetch path: only a running loader with chip enable drives data.
    always_comb begin
        if ((r_state == LdRun) && (rom_ce_i == ChipEnable)) begin
            rom_data_o = w_rdata;
        end else begin
            rom_data_o = ZeroWord;
        end
    end

    assign ld_ready_o = r_ready;
    assign cpu_rst_o  = r_cpu_rst;
    assign words_o    = r_words;
    assign load_err_o = r_err;

endmodule
